// File: rtl/cp0_multi_irq.sv
// cp0_multi_irq: coprocessor-0 block for the pipelined MIPS core with
// several edge-triggered interrupt lines and an optional timer source.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   oper                 00 none, 01 read, 10 store CPR[addr_w]=data_w, 11 ERET
//   addr_r / data_r      combinational register read (ID stage)
//   addr_w / data_w      register write (EXE stage)
//   ir_en                pipeline can accept an interrupt this cycle
//   ir_in                external interrupt lines (rising edge sets pending)
//   ret_addr             EPC value captured when an interrupt is taken
//   if_en                fetch accepted the redirect
//   jump_en / jump_addr  redirect request, held until if_en
//   ir                   one-cycle pulse when an interrupt is taken
//   ir_valid             1 while not inside a handler
//   ir_wait              some unmasked pending bit is set
module cp0_multi_irq #(
    parameter int unsigned NUM_IRQ   = 4,
    parameter int unsigned TIMER_EN  = 1,
    parameter int unsigned VECTORED  = 0,
    parameter int unsigned VEC_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         oper,
    input  logic [4:0]         addr_r,
    output logic [31:0]        data_r,
    input  logic [4:0]         addr_w,
    input  logic [31:0]        data_w,
    input  logic               ir_en,
    input  logic [NUM_IRQ-1:0] ir_in,
    input  logic [31:0]        ret_addr,
    input  logic               if_en,
    output logic               jump_en,
    output logic [31:0]        jump_addr,
    output logic               ir,
    output logic               ir_valid,
    output logic               ir_wait
);

    localparam int unsigned S = NUM_IRQ + TIMER_EN;

    typedef enum logic [0:0] {StRun, StHandler} state_e;

    state_e             state_q, state_d;
    logic               ie_q, ie_d;
    logic [S-1:0]       mask_q, mask_d;
    logic [S-1:0]       pend_q, pend_d;
    logic [4:0]         code_q, code_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        compare_q, compare_d;
    logic [31:0]        epc_q, epc_d;
    logic [31:0]        ehbr_q, ehbr_d;
    logic [NUM_IRQ-1:0] prev_q;
    logic               jump_en_q, jump_en_d;
    logic [31:0]        jump_addr_q, jump_addr_d;
    logic               ir_q;

    logic               wr, eret, take;
    logic [S-1:0]       masked, src_set, cmp_clr, w1c;
    logic [4:0]         take_code;
    logic [31:0]        target;

    assign wr     = (oper == 2'b10);
    assign eret   = (oper == 2'b11);
    assign masked = pend_q & mask_q;
    assign w1c    = (wr && addr_w == 5'd13) ? data_w[8 +: S] : '0;

    // Timer source occupies the pending bit just above the external lines.
    generate
        if (TIMER_EN != 0) begin : g_timer
            logic timer_hit;
            assign timer_hit = (count_q == compare_q) && (compare_q != '0);
            assign src_set   = {timer_hit, ir_in & ~prev_q};
            assign cmp_clr   = {(wr && addr_w == 5'd11), {NUM_IRQ{1'b0}}};
        end else begin : g_no_timer
            assign src_set = ir_in & ~prev_q;
            assign cmp_clr = '0;
        end
    endgenerate

    // Fixed priority: lowest index wins.
    always_comb begin
        take_code = '0;
        for (int i = int'(S) - 1; i >= 0; i--) begin
            if (masked[i]) take_code = 5'(i);
        end
    end

    assign take = (state_q == StRun) && ir_en && ie_q && (|masked) && !jump_en_q && !eret;

    assign target = (VECTORED != 0) ? ehbr_q + (32'(take_code) << VEC_SHIFT) : ehbr_q;

    always_comb begin
        state_d     = state_q;
        ie_d        = ie_q;
        mask_d      = mask_q;
        code_d      = code_q;
        compare_d   = compare_q;
        epc_d       = epc_q;
        ehbr_d      = ehbr_q;
        jump_en_d   = jump_en_q;
        jump_addr_d = jump_addr_q;
        count_d     = (TIMER_EN != 0) ? count_q + 32'd1 : count_q;

        if (wr) begin
            unique case (addr_w)
                5'd8: begin
                    ie_d   = data_w[0];
                    mask_d = data_w[8 +: S];
                end
                5'd9:    count_d   = data_w;
                5'd11:   compare_d = data_w;
                5'd14:   epc_d     = data_w;
                5'd15:   ehbr_d    = data_w;
                default: ;
            endcase
        end

        // Set wins over every kind of clear.
        pend_d = (pend_q & ~w1c & ~cmp_clr) | src_set;

        if (jump_en_q && if_en) begin
            jump_en_d   = 1'b0;
            jump_addr_d = '0;
        end

        // Take overrides a same-cycle EPC store; the jump uses the pre-store EHBR.
        if (take) begin
            epc_d       = ret_addr;
            code_d      = take_code;
            pend_d      = ((pend_q & ~w1c & ~cmp_clr) & ~(S'(1) << take_code)) | src_set;
            jump_en_d   = 1'b1;
            jump_addr_d = target;
            state_d     = StHandler;
        end

        if (eret) begin
            jump_en_d   = 1'b1;
            jump_addr_d = epc_q;
            state_d     = StRun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            ie_q        <= 1'b0;
            mask_q      <= '0;
            pend_q      <= '0;
            code_q      <= '0;
            count_q     <= '0;
            compare_q   <= '0;
            epc_q       <= '0;
            ehbr_q      <= '0;
            prev_q      <= '0;
            jump_en_q   <= 1'b0;
            jump_addr_q <= '0;
            ir_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ie_q        <= ie_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            code_q      <= code_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            epc_q       <= epc_d;
            ehbr_q      <= ehbr_d;
            prev_q      <= ir_in;
            jump_en_q   <= jump_en_d;
            jump_addr_q <= jump_addr_d;
            ir_q        <= take;
        end
    end

    always_comb begin
        data_r = '0;
        unique case (addr_r)
            5'd8: begin
                data_r[0]      = ie_q;
                data_r[8 +: S] = mask_q;
            end
            5'd9:  data_r = count_q;
            5'd11: data_r = compare_q;
            5'd13: begin
                data_r[8 +: S] = pend_q;
                data_r[6:2]    = code_q;
            end
            5'd14:   data_r = epc_q;
            5'd15:   data_r = ehbr_q;
            default: data_r = '0;
        endcase
    end

    assign jump_en   = jump_en_q;
    assign jump_addr = jump_addr_q;
    assign ir        = ir_q;
    assign ir_valid  = (state_q == StRun);
    assign ir_wait   = |masked;

endmodule

// File: tb/tb_cp0_multi_irq.sv
// Directed bench for cp0_multi_irq (NUM_IRQ=4, timer on, vectored, 16-byte spacing).
module tb_cp0_multi_irq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  oper;
    logic [4:0]  addr_r, addr_w;
    logic [31:0] data_r, data_w;
    logic        ir_en;
    logic [3:0]  ir_in;
    logic [31:0] ret_addr;
    logic        if_en;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        ir, ir_valid, ir_wait;

    int errors = 0;
    int checks = 0;

    cp0_multi_irq #(
        .NUM_IRQ  (4),
        .TIMER_EN (1),
        .VECTORED (1),
        .VEC_SHIFT(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .oper     (oper),
        .addr_r   (addr_r),
        .data_r   (data_r),
        .addr_w   (addr_w),
        .data_w   (data_w),
        .ir_en    (ir_en),
        .ir_in    (ir_in),
        .ret_addr (ret_addr),
        .if_en    (if_en),
        .jump_en  (jump_en),
        .jump_addr(jump_addr),
        .ir       (ir),
        .ir_valid (ir_valid),
        .ir_wait  (ir_wait)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr_r = a;
        #1;
        chk(tag, data_r, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [4:0] a, input logic [31:0] d);
        oper   = 2'b10;
        addr_w = a;
        data_w = d;
        tick();
        oper   = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; oper = 2'b00; addr_r = '0; addr_w = '0; data_w = '0;
        ir_en = 1'b0; ir_in = '0; ret_addr = '0; if_en = 1'b0;
        #12;
        chk("rst_jump_en", {31'b0, jump_en}, 32'd0);
        chk("rst_jump_addr", jump_addr, 32'd0);
        chk("rst_ir", {31'b0, ir}, 32'd0);
        chk("rst_ir_valid", {31'b0, ir_valid}, 32'd1);
        chk("rst_ir_wait", {31'b0, ir_wait}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: basic take of line 0
        store(5'd15, 32'h100);
        store(5'd8, 32'h0101);
        chk_reg("t1_status", 5'd8, 32'h0101);
        ret_addr = 32'h40;
        ir_en    = 1'b1;
        ir_in    = 4'b0001;
        tick();
        ir_in = 4'b0000;
        chk("t1_wait", {31'b0, ir_wait}, 32'd1);
        tick();
        chk("t1_ir", {31'b0, ir}, 32'd1);
        chk("t1_jump_en", {31'b0, jump_en}, 32'd1);
        chk("t1_jump_addr", jump_addr, 32'h100);
        chk("t1_ir_valid", {31'b0, ir_valid}, 32'd0);
        chk_reg("t1_epc", 5'd14, 32'h40);
        chk_reg("t1_cause", 5'd13, 32'h0);
        if_en = 1'b1;
        tick();
        chk("t1_ack_jump_en", {31'b0, jump_en}, 32'd0);
        chk("t1_ack_jump_addr", jump_addr, 32'd0);
        chk("t1_ir_pulse", {31'b0, ir}, 32'd0);
        if_en = 1'b0;
        oper  = 2'b11;
        tick();
        oper = 2'b00;
        chk("t1_eret_addr", jump_addr, 32'h40);
        chk("t1_eret_valid", {31'b0, ir_valid}, 32'd1);
        if_en = 1'b1;
        tick();
        if_en = 1'b0;

        // 2: lines 1 and 2 together, vectored to line 1
        store(5'd8, 32'h1F01);
        ret_addr = 32'h80;
        ir_in    = 4'b0110;
        tick();
        ir_in = 4'b0000;
        tick();
        chk("t2_ir", {31'b0, ir}, 32'd1);
        chk("t2_jump_addr", jump_addr, 32'h110);
        chk_reg("t2_cause", 5'd13, 32'h404);
        chk("t2_wait", {31'b0, ir_wait}, 32'd1);

        // 4: redirect held while fetch stalls
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_en", {31'b0, jump_en}, 32'd1);
            chk("t4_hold_addr", jump_addr, 32'h110);
        end
        if_en = 1'b1;
        tick();
        if_en = 1'b0;
        chk("t4_clr_en", {31'b0, jump_en}, 32'd0);
        chk("t4_clr_addr", jump_addr, 32'd0);

        // 3: no nested take, ERET, then line 3 taken
        store(5'd13, 32'h400);
        chk_reg("t3_w1c", 5'd13, 32'h004);
        ir_in = 4'b1000;
        tick();
        ir_in = 4'b0000;
        chk_reg("t3_cause", 5'd13, 32'h804);
        tick();
        chk("t3_no_take", {31'b0, ir}, 32'd0);
        chk("t3_in_handler", {31'b0, ir_valid}, 32'd0);
        ret_addr = 32'hC0;
        oper     = 2'b11;
        tick();
        oper = 2'b00;
        chk("t3_eret_en", {31'b0, jump_en}, 32'd1);
        chk("t3_eret_addr", jump_addr, 32'h80);
        chk("t3_eret_run", {31'b0, ir_valid}, 32'd1);
        tick();
        chk("t3_blocked", {31'b0, ir}, 32'd0);
        if_en = 1'b1;
        tick();
        if_en = 1'b0;
        chk("t3_blocked2", {31'b0, ir}, 32'd0);
        tick();
        chk("t3_take", {31'b0, ir}, 32'd1);
        chk("t3_jump_addr", jump_addr, 32'h130);
        chk_reg("t3_cause_code", 5'd13, 32'h00C);
        chk_reg("t3_epc", 5'd14, 32'hC0);

        // 5: timer source
        if_en = 1'b1;
        tick();
        if_en = 1'b0;
        oper  = 2'b11;
        tick();
        oper  = 2'b00;
        if_en = 1'b1;
        tick();
        if_en = 1'b0;
        ir_en = 1'b0;
        store(5'd8, 32'h1001);
        store(5'd11, 32'd20);
        store(5'd9, 32'd0);
        chk_reg("t5_count_load", 5'd9, 32'd0);
        repeat (20) tick();
        chk_reg("t5_count20", 5'd9, 32'd20);
        chk("t5_no_wait", {31'b0, ir_wait}, 32'd0);
        tick();
        chk("t5_wait", {31'b0, ir_wait}, 32'd1);
        chk_reg("t5_cause_pend", 5'd13, 32'h100C);
        store(5'd11, 32'd20);
        chk_reg("t5_cmp_clr", 5'd13, 32'h00C);
        chk("t5_wait_clr", {31'b0, ir_wait}, 32'd0);
        store(5'd9, 32'd18);
        ir_en = 1'b1;
        tick();
        tick();
        tick();
        chk("t5_pend_again", {31'b0, ir_wait}, 32'd1);
        tick();
        chk("t5_take", {31'b0, ir}, 32'd1);
        chk("t5_jump_addr", jump_addr, 32'h140);
        chk_reg("t5_cause_code", 5'd13, 32'h010);

        // 6: asynchronous reset mid-handler
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_jump_en", {31'b0, jump_en}, 32'd0);
        chk("t6_jump_addr", jump_addr, 32'd0);
        chk("t6_ir", {31'b0, ir}, 32'd0);
        chk("t6_ir_valid", {31'b0, ir_valid}, 32'd1);
        chk("t6_ir_wait", {31'b0, ir_wait}, 32'd0);
        chk_reg("t6_count", 5'd9, 32'd0);
        chk_reg("t6_epc", 5'd14, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t6_after_valid", {31'b0, ir_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
